// File: rtl/uart_rx_pkg.sv
// Shared receiver types and constants for the uart_rx block.
package uart_rx_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Bus between the uart receiver and the core IO path: line, baud config, byte handshake and flags.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [7:0]                baud_div;
    logic                      rx_in;
    logic                      rx_ack;
    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_strobe;
    logic                      frame_err;
    logic                      overrun;

    modport master (
        output baud_div, rx_in, rx_ack,
        input  rx_data, rx_valid, rx_strobe, frame_err, overrun
    );

    modport slave (
        input  baud_div, rx_in, rx_ack,
        output rx_data, rx_valid, rx_strobe, frame_err, overrun
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for uart_rx, first-word-fall-through; built only when UART_RX_FIFO_EN is defined.
`ifdef UART_RX_FIFO_EN
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = UART_DATA_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry an extra wrap bit so full and empty differ only in that bit.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/uart_rx.sv
// 8N1 oversampling uart receiver with holding register, or a receive FIFO when
// UART_RX_FIFO_EN is defined.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
`ifdef UART_RX_FIFO_EN
    ,
    parameter int unsigned FIFO_DEPTH = 4
`endif
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave rx_bus
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] OS_MID   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

    logic                      r_sync1;
    logic                      r_sync2;
    logic                      r_rx_prev;
    logic                      w_fall;

    logic [7:0]                r_div_cnt;
    logic [7:0]                r_div_lim;
    logic                      w_tick;
    logic                      w_restart;

    rx_state_t                 r_state;
    rx_state_t                 w_state_nxt;
    logic [TW-1:0]             r_tick_cnt;
    logic [TW-1:0]             w_tick_cnt_nxt;
    logic [BW-1:0]             r_bit_cnt;
    logic [BW-1:0]             w_bit_cnt_nxt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      w_good;
    logic                      w_ferr;

    logic                      r_strobe;
    logic                      r_ferr;
    logic                      r_ovr;
    logic                      w_lost;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_bus.rx_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;

    // The limit is latched on wrap (or restart) so a baud_div change never truncates a tick.
    assign w_tick = (r_div_cnt == r_div_lim);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_div_lim <= '0;
        end else if (w_restart || w_tick) begin
            r_div_cnt <= '0;
            r_div_lim <= rx_bus.baud_div;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_restart      = 1'b0;
        w_good         = 1'b0;
        w_ferr         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_restart      = 1'b1;
                    w_tick_cnt_nxt = '0;
                    w_state_nxt    = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_tick_cnt == OS_MID) begin
                        w_tick_cnt_nxt = '0;
                        w_bit_cnt_nxt  = '0;
                        w_state_nxt    = r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_tick_cnt == OS_LAST) begin
                        w_tick_cnt_nxt = '0;
                        w_shift_nxt    = {r_sync2, r_shift[UART_DATA_BITS-1:1]};
                        w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_nxt = ST_STOP;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_tick_cnt == OS_LAST) begin
                        w_tick_cnt_nxt = '0;
                        if (r_sync2) begin
                            w_good      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_ferr      = 1'b1;
                            w_state_nxt = ST_BREAK;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (r_sync2) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_FIFO_EN
    logic                      w_full;
    logic                      w_empty;
    logic [UART_DATA_BITS-1:0] w_head;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_strobe),
        .i_data  (r_shift),
        .i_pop   (rx_bus.rx_ack),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_lost          = r_strobe & w_full & ~rx_bus.rx_ack;
    assign rx_bus.rx_valid = ~w_empty;
    assign rx_bus.rx_data  = w_head;
`else
    logic                      r_valid;
    logic [UART_DATA_BITS-1:0] r_data;

    // A delivery coinciding with rx_ack replaces the byte instead of overrunning.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (r_strobe && (!r_valid || rx_bus.rx_ack)) begin
            r_valid <= 1'b1;
            r_data  <= r_shift;
        end else if (rx_bus.rx_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign w_lost          = r_strobe & r_valid & ~rx_bus.rx_ack;
    assign rx_bus.rx_valid = r_valid;
    assign rx_bus.rx_data  = r_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_strobe <= w_good;
            if (w_ferr) begin
                r_ferr <= 1'b1;
            end else if (rx_bus.rx_ack) begin
                r_ferr <= 1'b0;
            end
            if (w_lost) begin
                r_ovr <= 1'b1;
            end else if (rx_bus.rx_ack) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_strobe = r_strobe;
    assign rx_bus.frame_err = r_ferr;
    assign rx_bus.overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are generated from the line protocol, expected bytes queued at issue.
module tb_uart_rx;

    localparam int unsigned OS = 16;
`ifdef UART_RX_FIFO_EN
    localparam int unsigned CAP = 4;
`else
    localparam int unsigned CAP = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_rx_if intf();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk    (clk),
        .reset  (reset),
        .rx_bus (intf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] read_q[$];
    int exp_strobes = 0;
    int seen_strobes = 0;
    bit exp_ovr = 1'b0;
    bit auto_ack = 1'b1;
    int ack_req = 0;
    int flag_ack_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Consumer: the only driver of rx_ack; pops and compares whenever a byte is presented.
    initial begin : consumer
        logic [7:0] exp_b;
        intf.rx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && intf.rx_valid && (auto_ack || ack_req > 0)) begin
                if (read_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", intf.rx_data);
                end else begin
                    exp_b = read_q.pop_front();
                    chk("rx_data", {24'd0, intf.rx_data}, {24'd0, exp_b});
                end
                if (!auto_ack) ack_req--;
                intf.rx_ack = 1'b1;
                @(negedge clk);
                intf.rx_ack = 1'b0;
            end else if (!reset && !intf.rx_valid && flag_ack_req > 0) begin
                flag_ack_req--;
                intf.rx_ack = 1'b1;
                @(negedge clk);
                intf.rx_ack = 1'b0;
            end
        end
    end

    initial begin : strobe_mon
        forever begin
            @(negedge clk);
            if (intf.rx_strobe === 1'b1) seen_strobes++;
        end
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned bit_clks();
        return OS * (int'(intf.baud_div) + 1);
    endfunction

    task automatic drive(input logic v, input int unsigned n);
        intf.rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Model: a good frame strobes; it is readable if buffer space remains at issue, else overrun.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned low_bits,
                              input int unsigned idle_bits);
        int unsigned bt = bit_clks();
        if (stop) begin
            exp_strobes++;
            if (read_q.size() < CAP) read_q.push_back(b);
            else exp_ovr = 1'b1;
        end
        drive(1'b0, bt);
        for (int i = 0; i < 8; i++) drive(b[i], bt);
        drive(stop, bt);
        if (!stop) drive(1'b0, low_bits * bt);
        drive(1'b1, (idle_bits + 1) * bt);
    endtask

    task automatic glitch(input int unsigned len);
        drive(1'b0, len);
        drive(1'b1, 2 * bit_clks());
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((read_q.size() != 0 || ack_req != 0 || flag_ack_req != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_drain"}, {31'd0, (n < 500)}, 32'd1);
    endtask

    task automatic checkpoint(input string tag, input logic ferr_exp);
        wait_drain(tag);
        chk({tag, "_strobes"}, seen_strobes, exp_strobes);
        chk({tag, "_frame_err"}, {31'd0, intf.frame_err}, {31'd0, ferr_exp});
        chk({tag, "_overrun"}, {31'd0, intf.overrun}, {31'd0, exp_ovr});
    endtask

    task automatic clear_flags(input string tag);
        flag_ack_req = 1;
        wait_drain(tag);
        exp_ovr = 1'b0;
        chk({tag, "_ferr_clr"}, {31'd0, intf.frame_err}, 32'd0);
    endtask

    initial begin : stim
        int unsigned bt;
        int unsigned r;
        logic [7:0] b;
        logic [7:0] bauds [3];
        bauds[0] = 8'd0;
        bauds[1] = 8'd2;
        bauds[2] = 8'd5;

        intf.rx_in    = 1'b1;
        intf.baud_div = 8'd0;
        reset         = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, intf.rx_valid}, 32'd0);
        chk("rst_data", {24'd0, intf.rx_data}, 32'd0);
        chk("rst_strobe", {31'd0, intf.rx_strobe}, 32'd0);
        chk("rst_ferr", {31'd0, intf.frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, intf.overrun}, 32'd0);

        send_frame(8'hA5, 1'b1, 0, 1);
        checkpoint("t1", 1'b0);

        glitch(5);
        checkpoint("t2", 1'b0);
        chk("t2_valid", {31'd0, intf.rx_valid}, 32'd0);

        send_frame(8'h3C, 1'b0, 40, 1);
        checkpoint("t3", 1'b1);
        chk("t3_valid", {31'd0, intf.rx_valid}, 32'd0);
        clear_flags("t3");
        send_frame(8'h55, 1'b1, 0, 1);
        checkpoint("t3b", 1'b0);

        auto_ack = 1'b0;
        for (int i = 0; i <= int'(CAP); i++) begin
            b = (CAP == 1) ? 8'((i + 1) * 8'h11) : 8'(i + 1);
            send_frame(b, 1'b1, 0, 1);
        end
        chk("ovr_set", {31'd0, intf.overrun}, 32'd1);
        chk("ovr_valid", {31'd0, intf.rx_valid}, 32'd1);
        chk("ovr_head", {24'd0, intf.rx_data}, (CAP == 1) ? 32'h11 : 32'h01);
        chk("ovr_strobes", seen_strobes, exp_strobes);
        ack_req = CAP;
        exp_ovr = 1'b0;
        wait_drain("ovr");
        chk("ovr_valid_clr", {31'd0, intf.rx_valid}, 32'd0);
        chk("ovr_clr", {31'd0, intf.overrun}, 32'd0);

        send_frame(8'h99, 1'b1, 0, 1);
        chk("t6_held", {31'd0, intf.rx_valid}, 32'd1);
        b = 8'hC3;
        bt = bit_clks();
        drive(1'b0, bt);
        for (int i = 0; i < 3; i++) drive(b[i], bt);
        drive(b[3], bt / 2);
        reset = 1'b1;
        intf.rx_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        read_q.delete();
        @(negedge clk);
        chk("t6_valid", {31'd0, intf.rx_valid}, 32'd0);
        chk("t6_data", {24'd0, intf.rx_data}, 32'd0);
        chk("t6_ferr", {31'd0, intf.frame_err}, 32'd0);
        chk("t6_ovr", {31'd0, intf.overrun}, 32'd0);
        auto_ack = 1'b1;
        send_frame(8'h7E, 1'b1, 0, 1);
        checkpoint("t6", 1'b0);

        intf.baud_div = 8'd5;
        repeat (2) @(negedge clk);
        send_frame(8'hA5, 1'b1, 0, 1);
        checkpoint("b5_t1", 1'b0);
        glitch(5);
        checkpoint("b5_t2", 1'b0);

        foreach (bauds[k]) begin
            intf.baud_div = bauds[k];
            repeat (2) @(negedge clk);
            for (int n = 0; n < 12; n++) begin
                r = $urandom_range(0, 99);
                b = 8'($urandom);
                if (r < 70) begin
                    send_frame(b, 1'b1, 0, $urandom_range(0, 2));
                    checkpoint("rnd_good", 1'b0);
                end else if (r < 85) begin
                    glitch($urandom_range(1, OS / 2 * (int'(intf.baud_div) + 1) - 3));
                    checkpoint("rnd_glitch", 1'b0);
                end else begin
                    send_frame(b, 1'b0, $urandom_range(0, 2), $urandom_range(0, 2));
                    checkpoint("rnd_ferr", 1'b1);
                    clear_flags("rnd_ferr");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
